// File: rtl/cpu_pkg.sv
// Shared encoding constants for the parametrised teaching CPU: instruction
// classes, per-class opcodes, special register indices and field positions.
package cpu_pkg;

    localparam int INSTR_W = 16;

    // Instruction field positions: [15:14] cls, [13:11] op/dst, [10:8] src, [7:0] imm
    localparam int CLS_HI = 15;
    localparam int CLS_LO = 14;
    localparam int OP_HI  = 13;
    localparam int OP_LO  = 11;
    localparam int SRC_HI = 10;
    localparam int SRC_LO = 8;
    localparam int IMM_HI = 7;
    localparam int IMM_LO = 0;

    // Instruction classes
    localparam logic [1:0] CLS_MOV  = 2'b00;
    localparam logic [1:0] CLS_ALU  = 2'b01;
    localparam logic [1:0] CLS_FLOW = 2'b10;
    localparam logic [1:0] CLS_SYS  = 2'b11;

    // ALU opcodes (op[2]=0: binary on r0, op[2]=1: unary on rsrc)
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_INC = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_SHL = 3'b111;

    // Flow-control opcodes; 101..111 are reserved and behave as NOP
    localparam logic [2:0] OP_JNC = 3'b000;
    localparam logic [2:0] OP_JMP = 3'b001;
    localparam logic [2:0] OP_JZ  = 3'b010;
    localparam logic [2:0] OP_JNZ = 3'b011;
    localparam logic [2:0] OP_SET = 3'b100;

    // System opcodes; everything other than HALT is a NOP
    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_HALT = 3'b001;

    // Special register indices
    localparam logic [2:0] R_ACC = 3'd0;
    localparam logic [2:0] R_IN  = 3'd5;
    localparam logic [2:0] R_OUT = 3'd6;
    localparam logic [2:0] R_PC  = 3'd7;

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU: binary ops combine a (r0) with b (rsrc), unary ops act
// on b alone. carry_we tells the core whether this op defines a new carry.
module cpu_alu
    import cpu_pkg::*;
#(
    parameter int DATA_W = 4
) (
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result,
    output logic              carry,
    output logic              zero,
    output logic              carry_we
);

    logic [DATA_W:0] wide;

    // Result, carry-out and zero for the selected operation
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves one unassigned (no latch)
        wide     = '0;
        result   = '0;
        carry    = 1'b0;
        carry_we = 1'b0;
        case (op)
            OP_ADD: begin
                wide     = {1'b0, a} + {1'b0, b};
                result   = wide[DATA_W-1:0];
                carry    = wide[DATA_W];
                carry_we = 1'b1;
            end
            OP_OR:  result = a | b;
            OP_AND: result = a & b;
            OP_XOR: result = a ^ b;
            OP_INC: begin
                wide     = {1'b0, b} + (DATA_W + 1)'(1);
                result   = wide[DATA_W-1:0];
                carry    = wide[DATA_W];
                carry_we = 1'b1;
            end
            OP_NOT: result = ~b;
            OP_SHR: begin
                result   = b >> 1;
                carry    = b[0];
                carry_we = 1'b1;
            end
            OP_SHL: begin
                result   = b << 1;
                carry    = b[DATA_W-1];
                carry_we = 1'b1;
            end
            default: result = '0;
        endcase
        zero = (result == '0);
    end

endmodule

// File: rtl/cpu_core_param.sv
// Parametrised teaching CPU core. Eight architectural registers: r0..r4 and
// r6 (led) are stored, r5 mirrors btn every cycle, r7 reads as the PC. One
// instruction retires per cycle while imem_valid=1 and the core is not halted.
module cpu_core_param
    import cpu_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int PC_W   = 4
) (
    input  logic                clk,
    input  logic                reset,
    output logic [PC_W-1:0]     imem_addr,
    input  logic [INSTR_W-1:0]  imem_data,
    input  logic                imem_valid,
    input  logic [DATA_W-1:0]   btn,
    output logic [DATA_W-1:0]   led,
    output logic                halted
);

    // Architectural state; index 5 holds the last-sampled btn, r7 is pc
    logic [DATA_W-1:0] rf [0:6];
    logic [PC_W-1:0]   pc;
    logic              carry_flag;
    logic              zero_flag;

    // Decoded fields
    logic [1:0]        cls;
    logic [2:0]        op;
    logic [2:0]        src;
    logic [DATA_W-1:0] imm_d;
    logic [PC_W-1:0]   imm_pc;
    logic [DATA_W-1:0] rsrc;
    logic              retire;

    // Next-state controls
    logic [PC_W-1:0]   pc_next;
    logic              rf_we;
    logic [2:0]        rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic              carry_we;
    logic              zero_we;
    logic              halt_now;
    logic [2:0]        alu_tgt;

    // ALU outputs
    logic [DATA_W-1:0] alu_result;
    logic              alu_carry;
    logic              alu_zero;
    logic              alu_carry_we;

    assign cls    = imem_data[CLS_HI:CLS_LO];
    assign op     = imem_data[OP_HI:OP_LO];
    assign src    = imem_data[SRC_HI:SRC_LO];
    assign imm_d  = DATA_W'(imem_data[IMM_HI:IMM_LO]);
    assign imm_pc = PC_W'(imem_data[IMM_HI:IMM_LO]);
    assign retire = imem_valid && !halted;

    assign imem_addr = pc;
    assign led       = rf[R_OUT];

    // Source operand read; r7 returns the PC resized to the datapath width
    always_comb begin
        if (src == R_PC) begin
            rsrc = DATA_W'(pc);
        end else begin
            rsrc = rf[src];
        end
    end

    cpu_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .op       (op),
        .a        (rf[R_ACC]),
        .b        (rsrc),
        .result   (alu_result),
        .carry    (alu_carry),
        .zero     (alu_zero),
        .carry_we (alu_carry_we)
    );

    // Decode: PC next-state mux, register write port, flag and halt enables
    always_comb begin
        pc_next  = pc + PC_W'(1);
        rf_we    = 1'b0;
        rf_waddr = R_ACC;
        rf_wdata = rsrc;
        carry_we = 1'b0;
        zero_we  = 1'b0;
        halt_now = 1'b0;
        alu_tgt  = op[2] ? src : R_ACC;
        case (cls)
            CLS_MOV: begin
                if (op == R_PC) begin
                    pc_next = PC_W'(rsrc);
                end else if (op != R_IN) begin
                    rf_we    = 1'b1;
                    rf_waddr = op;
                end
            end
            CLS_ALU: begin
                zero_we  = 1'b1;
                carry_we = alu_carry_we;
                rf_wdata = alu_result;
                if (alu_tgt == R_PC) begin
                    pc_next = PC_W'(alu_result);
                end else if (alu_tgt != R_IN) begin
                    rf_we    = 1'b1;
                    rf_waddr = alu_tgt;
                end
            end
            CLS_FLOW: begin
                case (op)
                    OP_JNC: if (!carry_flag) pc_next = imm_pc;
                    OP_JMP: pc_next = imm_pc;
                    OP_JZ:  if (zero_flag) pc_next = imm_pc;
                    OP_JNZ: if (!zero_flag) pc_next = imm_pc;
                    OP_SET: begin
                        rf_we    = 1'b1;
                        rf_waddr = R_ACC;
                        rf_wdata = imm_d;
                    end
                    default: rf_we = 1'b0;
                endcase
            end
            CLS_SYS: begin
                case (op)
                    OP_NOP:  halt_now = 1'b0;
                    OP_HALT: halt_now = 1'b1;
                    default: halt_now = 1'b0;
                endcase
            end
            default: rf_we = 1'b0;
        endcase
    end

    // State update: reset wins, r5 samples btn every cycle, the rest only on retire
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the register file is a handful of flops, not a RAM, so it is reset like any other state
            rf         <= '{default: '0};
            pc         <= '0;
            carry_flag <= 1'b0;
            zero_flag  <= 1'b0;
            halted     <= 1'b0;
        end else if (retire) begin
            // NOTE: non-blocking assignments so every update reads pre-edge values
            pc <= pc_next;
            if (rf_we)    rf[rf_waddr] <= rf_wdata;
            if (carry_we) carry_flag   <= alu_carry;
            if (zero_we)  zero_flag    <= alu_zero;
            if (halt_now) halted       <= 1'b1;
        end
        rf[R_IN] <= btn;
    end

endmodule
